// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, parity modes, default bit period.
// Also used by uart_rx.
`ifndef UART_PKG_SV
`define UART_PKG_SV
package uart_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  // 50 MHz system clock, 9600 baud
  localparam int unsigned DIV_DEFAULT = 5208;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`endif

// File: rtl/uart_tx_if.sv
// Byte handshake between the device bus bridge (master) and the UART transmitter (slave).
interface uart_tx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIV-1, holds at DIV-1 until cleared; tick_c marks the last cycle.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick_c
);

  localparam int unsigned CW = cnt_width(DIV);

  logic [CW-1:0] cnt;

  assign tick_c = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!tick_c) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit; txd is a flop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DIV       = DIV_DEFAULT,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = PARITY_NONE
) (
  input  logic         clk,
  input  logic         rst_n,
  uart_tx_if.slave     bus,
  output logic         txd,
  output logic         busy
);

  localparam int unsigned BW = cnt_width(DATA_BITS);

  logic [2:0]           state, state_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [BW-1:0]        bit_cnt, bit_nxt;
  logic                 txd_nxt;
  logic                 par_q, par_nxt;
  logic                 ready_q;
  logic                 accept_c, tick_c, baud_clr_c;

  assign bus.tx_ready = ready_q;
  assign accept_c     = bus.tx_valid && ready_q;
  // Restart the bit period on accept and on every bit boundary
  assign baud_clr_c   = accept_c || (tick_c && (state != S_IDLE));

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (baud_clr_c),
    .tick_c (tick_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    bit_nxt   = bit_cnt;
    txd_nxt   = txd;
    par_nxt   = par_q;
    case (state)
      S_IDLE: begin
        if (accept_c) begin
          state_nxt = S_START;
          txd_nxt   = 1'b0;
          shift_nxt = bus.tx_data;
          bit_nxt   = '0;
          // Parity is taken from the captured byte since the shifter consumes it
          par_nxt   = (PARITY == PARITY_ODD) ? ~^bus.tx_data : ^bus.tx_data;
        end
      end
      S_START: begin
        if (tick_c) begin
          state_nxt = S_DATA;
          txd_nxt   = shift[0];
        end
      end
      S_DATA: begin
        if (tick_c) begin
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
            if (PARITY != PARITY_NONE) begin
              state_nxt = S_PARITY;
              txd_nxt   = par_q;
            end else begin
              state_nxt = S_STOP;
              txd_nxt   = 1'b1;
            end
          end else begin
            shift_nxt = shift >> 1;
            txd_nxt   = shift[1];
            bit_nxt   = bit_cnt + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (tick_c) begin
          state_nxt = S_STOP;
          txd_nxt   = 1'b1;
        end
      end
      S_STOP: begin
        if (tick_c) begin
          state_nxt = S_IDLE;
          txd_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        txd_nxt   = 1'b1;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      txd     <= 1'b1;
      par_q   <= 1'b0;
      ready_q <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      bit_cnt <= bit_nxt;
      txd     <= txd_nxt;
      par_q   <= par_nxt;
      ready_q <= (state_nxt == S_IDLE);
      busy    <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at DIV=4: scoreboard-decoded frames on the no-parity instance,
// directed timing and parity checks on even/odd-parity instances.
module tb_uart_tx;

  localparam int unsigned DIV = 4;

  logic clk;
  logic rst_n;
  logic txd0, txd1, txd2;
  logic busy0, busy1, busy2;

  uart_tx_if #(.DATA_BITS(8)) m0 ();
  uart_tx_if #(.DATA_BITS(8)) m1 ();
  uart_tx_if #(.DATA_BITS(8)) m2 ();

  uart_tx #(.DIV(DIV), .DATA_BITS(8), .PARITY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(m0), .txd(txd0), .busy(busy0));
  uart_tx #(.DIV(DIV), .DATA_BITS(8), .PARITY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(m1), .txd(txd1), .busy(busy1));
  uart_tx #(.DIV(DIV), .DATA_BITS(8), .PARITY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(m2), .txd(txd2), .busy(busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame decoder for dut0: cycle 1 is the first low sample, bits sampled mid-period
  bit        mon_act = 1'b0;
  int        mon_cyc = 0;
  logic [7:0] mon_byte;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (txd0 === 1'b0) begin
        mon_act = 1'b1;
        mon_cyc = 1;
      end
    end else begin
      mon_cyc++;
      if (mon_cyc == 2) begin
        chk("mon_start", 32'(txd0), 32'd0);
      end else if (mon_cyc > int'(DIV) + 1 && mon_cyc < int'(DIV) * 9 + 2 &&
                   (mon_cyc - 2) % int'(DIV) == 0) begin
        mon_byte[(mon_cyc - 2) / int'(DIV) - 1] = txd0;
      end else if (mon_cyc == int'(DIV) * 9 + 2) begin
        chk("mon_stop", 32'(txd0), 32'd1);
        chk("sb_has_exp", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("sb_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
        mon_act = 1'b0;
      end
    end
  end

  // Present a byte on dut0 and return at the negedge of cycle 1 after accept
  task automatic accept0(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!m0.tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_rdy", 32'(m0.tx_ready), 32'd1);
    m0.tx_data  = b;
    m0.tx_valid = 1'b1;
    exp_q.push_back(b);
    @(negedge clk);
    m0.tx_valid = 1'b0;
  endtask

  task automatic wait_ready0();
    int n;
    n = 0;
    while (!m0.tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", 32'(m0.tx_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int werr, rerr, hi, rdy, c, lows, bsy;
    logic [7:0] a5;
    logic expb, p1, p2;

    rst_n = 1'b0;
    m0.tx_data = '0; m0.tx_valid = 1'b0;
    m1.tx_data = '0; m1.tx_valid = 1'b0;
    m2.tx_data = '0; m2.tx_valid = 1'b0;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_txd", 32'(txd0), 32'd1);
    chk("rst_ready", 32'(m0.tx_ready), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    rst_n = 1'b1;
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (txd0 !== 1'b1) lows++;
    end
    chk("idle_high", 32'(lows), 32'd0);

    // 0xA5 waveform, cycle by cycle
    a5 = 8'hA5;
    accept0(a5);
    werr = 0;
    rerr = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k <= 4)       expb = 1'b0;
      else if (k <= 36) expb = a5[(k - 5) / 4];
      else              expb = 1'b1;
      if (txd0 !== expb) werr++;
      if (m0.tx_ready !== 1'b0 || busy0 !== 1'b1) rerr++;
      if (k < 40) @(negedge clk);
    end
    chk("a5_wave", 32'(werr), 32'd0);
    chk("a5_ready_low", 32'(rerr), 32'd0);
    @(negedge clk);
    chk("a5_ready_rise", 32'(m0.tx_ready), 32'd1);
    chk("a5_busy_fall", 32'(busy0), 32'd0);

    // Back-to-back 0x00 then 0xFF with tx_valid held
    @(negedge clk);
    m0.tx_data = 8'h00;
    m0.tx_valid = 1'b1;
    exp_q.push_back(8'h00);
    @(negedge clk);
    m0.tx_data = 8'hFF;
    exp_q.push_back(8'hFF);
    hi = 0;
    rdy = 0;
    c = 0;
    while (c < 100) begin
      @(negedge clk);
      c++;
      if (m0.tx_ready) rdy++;
      else if (rdy > 0) m0.tx_valid = 1'b0;
      if (txd0 === 1'b1) hi++;
      else if (hi > 0) break;
    end
    m0.tx_valid = 1'b0;
    chk("b2b_stop_len", 32'(hi), 32'd5);
    chk("b2b_idle_cycles", 32'(rdy), 32'd1);
    wait_ready0();

    // Ignore tx_valid while busy
    accept0(8'h3C);
    repeat (9) @(negedge clk);
    m0.tx_data = 8'h99;
    m0.tx_valid = 1'b1;
    @(negedge clk);
    chk("ign_ready_low", 32'(m0.tx_ready), 32'd0);
    m0.tx_valid = 1'b0;
    m0.tx_data = 8'h00;
    c = 11;
    while (!m0.tx_ready && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("ign_frame_len", 32'(c), 32'd41);
    lows = 0;
    bsy = 0;
    repeat (30) begin
      @(negedge clk);
      if (txd0 !== 1'b1) lows++;
      if (busy0 !== 1'b0) bsy++;
    end
    chk("ign_no_resend", 32'(lows), 32'd0);
    chk("ign_not_busy", 32'(bsy), 32'd0);

    // Parity: 0x07 on even and odd instances
    @(negedge clk);
    m1.tx_data = 8'h07; m1.tx_valid = 1'b1;
    m2.tx_data = 8'h07; m2.tx_valid = 1'b1;
    @(negedge clk);
    m1.tx_valid = 1'b0;
    m2.tx_valid = 1'b0;
    bsy = 0;
    p1 = 1'bx;
    p2 = 1'bx;
    for (int k = 1; k <= 50; k++) begin
      if (busy1 === 1'b1) bsy++;
      if (k == 38) begin
        p1 = txd1;
        p2 = txd2;
      end
      if (k == 44) chk("par_ready_low", 32'(m1.tx_ready), 32'd0);
      if (k == 45) chk("par_ready_rise", 32'(m1.tx_ready), 32'd1);
      @(negedge clk);
    end
    chk("par_even_bit", 32'(p1), 32'd1);
    chk("par_odd_bit", 32'(p2), 32'd0);
    chk("par_frame_len", 32'(bsy), 32'd44);

    // Reset during data bit 3 of 0xA0 (bit 3 is 0)
    accept0(8'hA0);
    repeat (17) @(negedge clk);
    chk("mid_txd_low", 32'(txd0), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_txd", 32'(txd0), 32'd1);
    chk("mid_rst_ready", 32'(m0.tx_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy0), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    accept0(8'h55);
    wait_ready0();
    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
